// File: rtl/parser_pkg.sv
// Shared definitions for the payload buffer write path.
// The MEM_DEPTH/MAX_BEATS defaults are also used by the memory controller
// and the reader, so the slot geometry matches on both sides of the buffer.
package parser_pkg;

    localparam int BUS_WIDTH_DEF = 32;
    localparam int MAX_BEATS_DEF = 16;
    localparam int MEM_DEPTH_DEF = 100;
    localparam int SLOT_W_DEF    = $clog2(MEM_DEPTH_DEF);
    localparam int LEN_W_DEF     = $clog2(MAX_BEATS_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [SLOT_W_DEF-1:0] slot;
        logic [LEN_W_DEF-1:0]  len;
        logic                  trunc;
    } payload_desc_t;

endpackage

// File: rtl/payload_buffer_writer_if.sv
// Bundle of the writer's stream, memory-write, descriptor and release signals.
//   master : the payload_buffer_writer side
//   slave  : the environment (parser, memory controller, reader)
interface payload_buffer_writer_if
    import parser_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
);
    localparam int SLOT_W = $clog2(MEM_DEPTH);
    localparam int LEN_W  = $clog2(MAX_BEATS + 1);
    localparam int STRB_W = BUS_WIDTH / 8;

    // input beat stream
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_sop;
    logic                 in_eop;
    // memory write port
    logic                 w_en;
    logic [STRB_W-1:0]    w_strb;
    logic [31:0]          w_addr_out;
    logic [BUS_WIDTH-1:0] data_out;
    // descriptor stream
    logic                 desc_valid;
    logic                 desc_ready;
    logic [SLOT_W-1:0]    desc_slot;
    logic [LEN_W-1:0]     desc_len;
    logic                 desc_trunc;
    // slot release from the reader
    logic                 rel_valid;
    logic                 err_rel_underflow;

    modport master (
        input  in_valid, in_data, in_sop, in_eop, desc_ready, rel_valid,
        output in_ready, w_en, w_strb, w_addr_out, data_out,
               desc_valid, desc_slot, desc_len, desc_trunc, err_rel_underflow
    );

    modport slave (
        output in_valid, in_data, in_sop, in_eop, desc_ready, rel_valid,
        input  in_ready, w_en, w_strb, w_addr_out, data_out,
               desc_valid, desc_slot, desc_len, desc_trunc, err_rel_underflow
    );

endinterface

// File: rtl/payload_buffer_writer_slot_ring.sv
// slot_ring: occupancy tracking for the circular slot buffer.
//   CLK, reset : clock, async active-low reset
//   commit     : writer hands a filled slot to the reader (head advances)
//   rel        : reader frees the oldest occupied slot (tail advances)
//   head       : slot currently being filled
//   full/empty : used == DEPTH / used == 0
//   underflow  : sticky, a release arrived with no slot occupied
module slot_ring #(
    parameter  int DEPTH = 100,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             commit,
    input  logic             rel,
    output logic [PTR_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             underflow
);
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] used;
    logic             rel_ok;

    assign full   = (used == CNT_W'(DEPTH));
    assign empty  = (used == '0);
    assign rel_ok = rel && !empty;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            used      <= '0;
            underflow <= 1'b0;
        end else begin
            if (commit) head <= wrap_inc(head);
            if (rel_ok) tail <= wrap_inc(tail);
            // commit and release together leave the count unchanged
            case ({commit, rel_ok})
                2'b10:   used <= used + CNT_W'(1);
                2'b01:   used <= used - CNT_W'(1);
                default: used <= used;
            endcase
            if (rel && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/payload_buffer_writer.sv
// payload_buffer_writer: packs payload packets into fixed-size slots of the
// circular payload buffer and emits one descriptor per committed packet.
//   CLK, reset : clock, async active-low reset
//   bus        : master side of payload_buffer_writer_if
//                (input stream, memory write port, descriptor, release)
//
// state  | meaning
// IDLE   | waiting for an sop beat; ready only while a free slot exists
// WRITE  | storing beats into the current slot, dropping beyond MAX_BEATS
// COMMIT | descriptor presented, waiting for desc_ready
module payload_buffer_writer
    import parser_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input logic                    CLK,
    input logic                    reset,
    payload_buffer_writer_if.master bus
);
    localparam int SLOT_W = $clog2(MEM_DEPTH);
    localparam int LEN_W  = $clog2(MAX_BEATS + 1);
    localparam int STRB_W = BUS_WIDTH / 8;

    wr_state_t            state, state_nx;
    logic                 run;
    logic [LEN_W-1:0]     beat, beat_nx;
    logic                 trunc, trunc_nx;
    logic                 wr_nx;
    logic [31:0]          addr_nx;
    logic                 commit;
    logic                 in_ready;
    logic                 desc_valid;
    logic                 accept;

    logic                 w_en_q;
    logic [STRB_W-1:0]    w_strb_q;
    logic [31:0]          w_addr_q;
    logic [BUS_WIDTH-1:0] data_q;

    logic [SLOT_W-1:0]    head;
    logic                 full;
    logic                 empty;
    logic                 underflow;
    logic                 unused_ring;

    slot_ring #(.DEPTH(MEM_DEPTH)) u_ring (
        .CLK       (CLK),
        .reset     (reset),
        .commit    (commit),
        .rel       (bus.rel_valid),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .underflow (underflow)
    );

    assign unused_ring = empty;
    assign accept      = bus.in_valid && in_ready;
    // beat is 0 while IDLE, so the sop beat lands at the slot base
    assign addr_nx     = 32'(head) * 32'(MAX_BEATS) + 32'(beat);

    always_comb begin
        state_nx   = state;
        beat_nx    = beat;
        trunc_nx   = trunc;
        wr_nx      = 1'b0;
        commit     = 1'b0;
        in_ready   = 1'b0;
        desc_valid = 1'b0;
        case (state)
            IDLE: begin
                // run holds ready low until the first edge after reset release
                in_ready = run && !full;
                if (accept && bus.in_sop) begin
                    wr_nx    = 1'b1;
                    beat_nx  = LEN_W'(1);
                    trunc_nx = 1'b0;
                    state_nx = bus.in_eop ? COMMIT : WRITE;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (beat < LEN_W'(MAX_BEATS)) begin
                        wr_nx   = 1'b1;
                        beat_nx = beat + LEN_W'(1);
                    end else begin
                        trunc_nx = 1'b1;
                    end
                    if (bus.in_eop) state_nx = COMMIT;
                end
            end
            COMMIT: begin
                desc_valid = 1'b1;
                if (bus.desc_ready) begin
                    commit   = 1'b1;
                    beat_nx  = '0;
                    trunc_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            run      <= 1'b0;
            beat     <= '0;
            trunc    <= 1'b0;
            w_en_q   <= 1'b0;
            w_strb_q <= '0;
            w_addr_q <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nx;
            run      <= 1'b1;
            beat     <= beat_nx;
            trunc    <= trunc_nx;
            w_en_q   <= wr_nx;
            w_strb_q <= {STRB_W{wr_nx}};
            if (wr_nx) begin
                w_addr_q <= addr_nx;
                data_q   <= bus.in_data;
            end
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.w_en              = w_en_q;
    assign bus.w_strb            = w_strb_q;
    assign bus.w_addr_out        = w_addr_q;
    assign bus.data_out          = data_q;
    // head and beat do not move while in COMMIT, so the fields hold stable
    assign bus.desc_valid        = desc_valid;
    assign bus.desc_slot         = desc_valid ? head : '0;
    assign bus.desc_len          = desc_valid ? beat : '0;
    assign bus.desc_trunc        = desc_valid && trunc;
    assign bus.err_rel_underflow = underflow;

endmodule

// File: tb/tb_payload_buffer_writer.sv
module tb_payload_buffer_writer;
    import parser_pkg::*;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    payload_buffer_writer_if bus ();

    payload_buffer_writer dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    typedef struct {
        int            n;
        logic [31:0]   base;
        payload_desc_t exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (bus.w_en === 1'b1) begin
            wq_addr.push_back(bus.w_addr_out);
            wq_data.push_back(bus.data_out);
            check("w_strb", 32'(bus.w_strb), 32'hF);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready), 0);
        check({tag, "_w_en"},       32'(bus.w_en), 0);
        check({tag, "_w_strb"},     32'(bus.w_strb), 0);
        check({tag, "_w_addr"},     bus.w_addr_out, 0);
        check({tag, "_data_out"},   bus.data_out, 0);
        check({tag, "_desc_valid"}, 32'(bus.desc_valid), 0);
        check({tag, "_desc_slot"},  32'(bus.desc_slot), 0);
        check({tag, "_desc_len"},   32'(bus.desc_len), 0);
        check({tag, "_desc_trunc"}, 32'(bus.desc_trunc), 0);
        check({tag, "_err"},        32'(bus.err_rel_underflow), 0);
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.in_sop     = 1'b0;
        bus.in_eop     = 1'b0;
        bus.desc_ready = 1'b0;
        bus.rel_valid  = 1'b0;
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 300) begin
            cycle();
            cnt++;
        end
        if (cnt >= 300) check(name, 32'(bus.in_ready), 1);
    endtask

    task automatic wait_desc(input string name);
        int cnt = 0;
        while (bus.desc_valid !== 1'b1 && cnt < 100) begin
            cycle();
            cnt++;
        end
        if (cnt >= 100) check(name, 32'(bus.desc_valid), 1);
    endtask

    task automatic send_packet(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 32'(i);
            bus.in_sop   = (i == 0);
            bus.in_eop   = (i == n - 1);
            wait_ready("in_ready_timeout");
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic desc_handshake();
        bus.desc_ready = 1'b1;
        cycle();
        bus.desc_ready = 1'b0;
    endtask

    task automatic run_vec(input int n, input logic [31:0] base, input payload_desc_t exp,
                           input string tag);
        wq_addr.delete();
        wq_data.delete();
        send_packet(n, base);
        wait_desc({tag, "_desc_timeout"});
        check({tag, "_desc_slot"},  32'(bus.desc_slot), 32'(exp.slot));
        check({tag, "_desc_len"},   32'(bus.desc_len), 32'(exp.len));
        check({tag, "_desc_trunc"}, 32'(bus.desc_trunc), 32'(exp.trunc));
        desc_handshake();
        check({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(exp.len));
        for (int i = 0; i < int'(exp.len) && i < wq_addr.size(); i++) begin
            check({tag, "_addr"}, wq_addr[i], 32'(exp.slot) * MAX_BEATS_DEF + 32'(i));
            check({tag, "_data"}, wq_data[i], base + 32'(i));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4,  32'h0000_1000, '{slot: 7'd0, len: 5'd4,  trunc: 1'b0}};
        vecs[1] = '{4,  32'h0000_2000, '{slot: 7'd1, len: 5'd4,  trunc: 1'b0}};
        vecs[2] = '{4,  32'h0000_3000, '{slot: 7'd2, len: 5'd4,  trunc: 1'b0}};
        vecs[3] = '{20, 32'h0000_4000, '{slot: 7'd3, len: 5'd16, trunc: 1'b1}};
        vecs[4] = '{16, 32'h0000_5000, '{slot: 7'd4, len: 5'd16, trunc: 1'b0}};
        vecs[5] = '{17, 32'h0000_6000, '{slot: 7'd5, len: 5'd16, trunc: 1'b1}};
        vecs[6] = '{1,  32'h0000_7000, '{slot: 7'd6, len: 5'd1,  trunc: 1'b0}};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_sop     = 1'b0;
        bus.in_eop     = 1'b0;
        bus.desc_ready = 1'b0;
        bus.rel_valid  = 1'b0;

        // reset state, then a single sop&eop beat with exact latency checks
        repeat (2) cycle();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) cycle();
        check("idle_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        bus.in_eop   = 1'b1;
        bus.in_data  = 32'hA5A5_A5A5;
        cycle();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        check("single_w_en",       32'(bus.w_en), 1);
        check("single_w_addr",     bus.w_addr_out, 0);
        check("single_data",       bus.data_out, 32'hA5A5_A5A5);
        check("single_desc_valid", 32'(bus.desc_valid), 1);
        check("single_desc_slot",  32'(bus.desc_slot), 0);
        check("single_desc_len",   32'(bus.desc_len), 1);
        check("single_desc_trunc", 32'(bus.desc_trunc), 0);
        check("single_commit_rdy", 32'(bus.in_ready), 0);
        cycle();
        check("single_w_en_once",  32'(bus.w_en), 0);
        check("single_desc_hold",  32'(bus.desc_valid), 1);
        desc_handshake();
        check("single_desc_drop",  32'(bus.desc_valid), 0);

        // table of packets from a fresh buffer
        do_reset();
        foreach (vecs[k]) run_vec(vecs[k].n, vecs[k].base, vecs[k].exp, $sformatf("vec%0d", k));

        // fill the remaining slots without releases
        for (int k = 7; k < 100; k++)
            run_vec(1, 32'h0001_0000 + 32'(k), '{slot: 7'(k), len: 5'd1, trunc: 1'b0}, "fill");
        check("full_ready", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        bus.in_eop   = 1'b1;
        bus.in_data  = 32'hB000_0000;
        wq_addr.delete();
        wq_data.delete();
        repeat (3) begin
            cycle();
            check("full_hold_ready", 32'(bus.in_ready), 0);
            check("full_no_write",   32'(bus.w_en), 0);
        end
        bus.rel_valid = 1'b1;
        cycle();
        bus.rel_valid = 1'b0;
        check("release_ready", 32'(bus.in_ready), 1);
        cycle();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        check("wrap_w_en",   32'(bus.w_en), 1);
        check("wrap_w_addr", bus.w_addr_out, 0);
        check("wrap_data",   bus.data_out, 32'hB000_0000);
        check("wrap_slot",   32'(bus.desc_slot), 0);
        desc_handshake();

        // stalled descriptor, then commit together with a release
        bus.rel_valid = 1'b1;
        cycle();
        bus.rel_valid = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        send_packet(2, 32'hC000_0000);
        wait_desc("stall_desc_timeout");
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(bus.desc_valid), 1);
            check("stall_slot",  32'(bus.desc_slot), 1);
            check("stall_len",   32'(bus.desc_len), 2);
            check("stall_trunc", 32'(bus.desc_trunc), 0);
            check("stall_ready", 32'(bus.in_ready), 0);
            cycle();
        end
        check("stall_nwrites", 32'(wq_addr.size()), 2);
        if (wq_addr.size() == 2) begin
            check("stall_addr0", wq_addr[0], 16);
            check("stall_addr1", wq_addr[1], 17);
        end
        bus.desc_ready = 1'b1;
        bus.rel_valid  = 1'b1;
        cycle();
        bus.desc_ready = 1'b0;
        bus.rel_valid  = 1'b0;
        check("commit_rel_ready", 32'(bus.in_ready), 1);
        run_vec(1, 32'hC100_0000, '{slot: 7'd2, len: 5'd1, trunc: 1'b0}, "after_both");
        check("refull_ready", 32'(bus.in_ready), 0);

        // release underflow is sticky and leaves the count alone
        do_reset();
        check("uf_clear", 32'(bus.err_rel_underflow), 0);
        bus.rel_valid = 1'b1;
        cycle();
        bus.rel_valid = 1'b0;
        check("uf_set", 32'(bus.err_rel_underflow), 1);
        repeat (3) cycle();
        check("uf_sticky", 32'(bus.err_rel_underflow), 1);
        check("uf_ready",  32'(bus.in_ready), 1);

        // reset in the middle of a packet
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sop   = (i == 0);
            bus.in_eop   = 1'b0;
            bus.in_data  = 32'hD000_0000 + 32'(i);
            cycle();
        end
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        cycle();
        reset = 1'b1;
        repeat (2) cycle();
        check("midrst_no_desc", 32'(bus.desc_valid), 0);
        run_vec(1, 32'hE000_0000, '{slot: 7'd0, len: 5'd1, trunc: 1'b0}, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/payload_buffer_writer.md
# payload_buffer_writer

Write-side front end of the payload buffer. Accepts parsed payload beats on a valid/ready stream and packs each packet into a fixed-size slot of a circular buffer in the block RAM owned by the memory controller. Drives that controller's write port and emits one descriptor per committed packet. Applies backpressure when all slots are held by the read side.

## Interface
- BUS_WIDTH, 32: data beat width; the memory write strobe is BUS_WIDTH/8 bits.
- MAX_BEATS, 16: slot size in beats; beats beyond this are truncated.
- MEM_DEPTH, 100: number of slots in the circular buffer.
- SLOT_W, $clog2(MEM_DEPTH): slot index width.
- LEN_W, $clog2(MAX_BEATS+1): beat-count width.
- CLK  in  1  sole clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  BUS_WIDTH  payload beat.
- in_sop  in  1  first beat of a packet.
- in_eop  in  1  last beat of a packet; may coincide with in_sop.
- w_en  out  1  memory write enable.
- w_strb  out  BUS_WIDTH/8  byte write strobe; all ones when w_en is 1, else 0.
- w_addr_out  out  32  word address, computed as slot*MAX_BEATS + beat.
- data_out  out  BUS_WIDTH  write data.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  descriptor consumed.
- desc_slot  out  SLOT_W  slot index of the packet.
- desc_len  out  LEN_W  beats stored, 1..MAX_BEATS.
- desc_trunc  out  1  packet exceeded MAX_BEATS.
- rel_valid  in  1  one-cycle pulse from the reader freeing the oldest occupied slot.
- err_rel_underflow  out  1  sticky; set by a release while no slot is occupied.

## Operation
- States:
  - IDLE: in_ready = (used < MEM_DEPTH). An accepted beat with in_sop starts a packet. Accepted beats without in_sop are discarded and do not change state.
  - WRITE: in_ready = 1. Each accepted beat with beat < MAX_BEATS is written and increments beat; further beats are dropped and set trunc. An accepted in_eop goes to COMMIT.
  - COMMIT: in_ready = 0; desc_valid = 1. On desc_ready: used += 1, head advances, and the state goes to IDLE.
- The packet's first beat (sop) is written at beat 0. An sop && eop beat goes directly to COMMIT with len = 1.
- An in_sop seen during WRITE is treated as ordinary data; no resynchronisation is done.
- head and tail wrap from MEM_DEPTH-1 to 0. used ranges over 0..MEM_DEPTH.
- rel_valid: if used > 0, tail advances and used -= 1. Otherwise it has no effect and sets err_rel_underflow.
- Simultaneous commit and release in one cycle leave used unchanged; both pointers advance.
- Descriptors are emitted in slot order. desc_* fields hold stable from assertion of desc_valid until the handshake.

## Timing
- Write latency: a beat accepted at cycle N drives w_en/w_addr_out/data_out at cycle N+1, for exactly one cycle. All write outputs are registered.
- desc_valid asserts in the cycle after eop is accepted, which is also the cycle eop's write is presented.
- in_ready is combinational from state and used only, never from in_valid.
- Full condition: with used = MEM_DEPTH, in_ready stays 0 in IDLE. A release in cycle N raises in_ready in cycle N+1.
- Reset values: in_ready 0 while reset is asserted, then per IDLE rule. All other outputs are 0; state IDLE; head, tail, used and beat 0; err_rel_underflow cleared.
- Reset asserted mid-packet abandons the partial slot with no descriptor. Any pending write is cancelled.

## Structure
- parser_pkg holds:
  - a packed struct payload_desc_t {slot, len, trunc};
  - the state enum {IDLE, WRITE, COMMIT};
  - the MEM_DEPTH and MAX_BEATS defaults, shared with the memory controller and the reader.
- Sub-module slot_ring: owns head, tail and used; inputs commit and release; outputs full, empty and underflow. The address multiply is a constant multiply kept in the top level.

## Test plan
- Single beat sop&eop, data 0xA5A5A5A5, slot 0 -> w_addr 0, data_out 0xA5A5A5A5 at N+1; descriptor {slot 0, len 1, trunc 0}.
- Three 4-beat packets -> write addresses 0-3, 16-19, 32-35; descriptors for slots 0, 1, 2 in order.
- 20-beat packet, MAX_BEATS = 16 -> 16 writes at addresses 0-15, beats 17-20 accepted and not written; descriptor {len 16, trunc 1}.
- Fill 100 slots with no releases -> in_ready 0 in IDLE. Pulse rel_valid -> in_ready 1 next cycle; the next packet lands in slot 0 at address 0 (wrap).
- desc_ready held 0 for 5 cycles -> descriptor stable and in_ready 0 throughout. Commit coinciding with rel_valid -> used unchanged.
- rel_valid with used = 0 -> err_rel_underflow set and stays set. Reset asserted mid-packet -> all outputs 0; next packet starts at slot 0.
